// File: rtl/od_sched_pkg.sv
// Shared types and defaults for the stereo overdrive scheduler.
package od_sched_pkg;

  typedef enum logic [1:0] {IDLE, L_SETTLE, R_SETTLE} od_sched_state_t;

  localparam int SAMPLE_W_DEFAULT = 16;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/od_stereo_scheduler.sv
// Time-multiplexes one shared overdrive datapath across the left and right
// channels of a stereo frame, with effect settings frozen per frame.
module od_stereo_scheduler
  import od_sched_pkg::*;
#(
  parameter int SAMPLE_W      = SAMPLE_W_DEFAULT,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                gain_req,
  input  logic                bypass_req,
  input  logic                overrun_clr,
  output logic [SAMPLE_W-1:0] od_input_frame,
  output logic                od_gain,
  input  logic [SAMPLE_W-1:0] od_output_frame,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                busy,
  output logic                overrun
);

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  od_sched_state_t     state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] od_input_q, od_input_d;
  logic                od_gain_q, od_gain_d;
  logic [SAMPLE_W-1:0] right_sh_q, right_sh_d;
  logic [SAMPLE_W-1:0] left_res_q, left_res_d;
  logic [SAMPLE_W-1:0] out_left_q, out_left_d;
  logic [SAMPLE_W-1:0] out_right_q, out_right_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    od_input_d  = od_input_q;
    od_gain_d   = od_gain_q;
    right_sh_d  = right_sh_q;
    left_res_d  = left_res_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          right_sh_d = in_right;
          if (bypass_req) begin
            // Bypass frames never touch the shared datapath.
            out_left_d  = in_left;
            out_right_d = in_right;
            out_valid_d = 1'b1;
          end else begin
            od_input_d = in_left;
            od_gain_d  = gain_req;
            cnt_d      = CNT_RELOAD;
            state_d    = L_SETTLE;
          end
        end
      end
      L_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          left_res_d = od_output_frame;
          od_input_d = right_sh_q;
          cnt_d      = CNT_RELOAD;
          state_d    = R_SETTLE;
        end
      end
      R_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_left_d  = left_res_q;
          out_right_d = od_output_frame;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh overrun outranks a simultaneous clear.
    if (in_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, matching hardware.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      od_input_q  <= '0;
      od_gain_q   <= 1'b0;
      right_sh_q  <= '0;
      left_res_q  <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      od_input_q  <= od_input_d;
      od_gain_q   <= od_gain_d;
      right_sh_q  <= right_sh_d;
      left_res_q  <= left_res_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign od_input_frame = od_input_q;
  assign od_gain        = od_gain_q;
  assign out_valid      = out_valid_q;
  assign out_left       = out_left_q;
  assign out_right      = out_right_q;
  assign busy           = (state_q != IDLE);
  assign overrun        = overrun_q;

endmodule
